dotprod_accumulator: RTL

DOTPROD_ACCUMULATOR -- requirements
Module: dotprod_accumulator

---
 rtl/dotprod_acc_pkg.sv | 15 +
 rtl/dotprod_accumulator_cpa_resolve.sv | 20 ++
 rtl/dotprod_accumulator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dotprod_acc_pkg.sv
// Shared definitions for the dot-product accumulator: FSM state encoding
// and default width constants.
package dotprod_acc_pkg;

    localparam int DEF_IN_W  = 20;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dotprod_accumulator_cpa_resolve.sv
// Carry-propagate resolution of a redundant (sum, carry) pair into a single
// two's-complement word, sign-extended from IN_W to ACC_W. Purely combinational.
module cpa_resolve #(
    parameter int IN_W  = 20,
    parameter int ACC_W = 32
) (
    input  logic [IN_W-1:0]  sum_i,
    input  logic [IN_W-1:0]  carry_i,
    output logic [ACC_W-1:0] value_o
);

    logic [IN_W-1:0] raw;

    // Add modulo 2^IN_W, then sign-extend using bit IN_W-1.
    always_comb begin
        raw     = sum_i + carry_i;
        value_o = ACC_W'($signed(raw));
    end

endmodule

// File: rtl/dotprod_accumulator.sv
// Dot-product accumulator: resolves redundant beats and sums a job of len_i
// beats into a signed ACC_W accumulator with a sticky overflow flag.
// Optional build macro: DOTPROD_ACC_SATURATE_EN (clamp on overflow instead
// of wrapping).
module dotprod_accumulator
    import dotprod_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  sum_i,
    input  logic [IN_W-1:0]  carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             overflow_o,
    output logic             busy_o
);

    state_e             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic               ovf_reg, ovf_next;
    logic [LEN_W-1:0]   cnt_reg, cnt_next;

    logic [ACC_W-1:0]   beat_val;
    logic [ACC_W-1:0]   add_raw;
    logic [ACC_W-1:0]   add_res;
    logic               add_ovf;

    cpa_resolve #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_cpa (
        .sum_i   (sum_i),
        .carry_i (carry_i),
        .value_o (beat_val)
    );

    // Signed add with overflow detection; result wraps or clamps by build option.
    always_comb begin
        add_raw = acc_reg + beat_val;
        add_ovf = (acc_reg[ACC_W-1] == beat_val[ACC_W-1]) &&
                  (add_raw[ACC_W-1] != acc_reg[ACC_W-1]);
        add_res = add_raw;
`ifdef DOTPROD_ACC_SATURATE_EN
        // Both operands share a sign on overflow, so acc's sign picks the rail.
        if (add_ovf) begin
            add_res = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        add_res = add_raw;
`endif
    end

    // Next-state logic for the IDLE -> ACCUM -> DONE job sequence.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = len_i;
                    state_next = (len_i == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid_i) begin
                    acc_next = add_res;
                    ovf_next = ovf_reg | add_ovf;
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == LEN_W'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A start in this cycle is dropped: the FSM is not yet IDLE.
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any job in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        in_ready_o  = (state_reg == ST_ACCUM);
        out_valid_o = (state_reg == ST_DONE);
        busy_o      = (state_reg != ST_IDLE);
        acc_o       = acc_reg;
        overflow_o  = ovf_reg;
    end

endmodule
